// File: rtl/pc_next_if.sv
// Bundle between the PC stage and its neighbours: stall/redirect requests in,
// fetch PC, increment, pending status and flush control out.
interface pc_next_if #(
  parameter int PC_W   = 9,
  parameter int DATA_W = 32,
  parameter int N_SRC  = 3
);
  logic                    stall;
  logic [N_SRC-1:0]        redir_valid;
  logic [N_SRC*DATA_W-1:0] redir_target;
  logic [PC_W-1:0]         pc;
  logic [PC_W-1:0]         pc_plus;
  logic                    pend_valid;
  logic [N_SRC-1:0]        redir_src;
  logic                    flush;

  modport master (
    output stall, redir_valid, redir_target,
    input  pc, pc_plus, pend_valid, redir_src, flush
  );

  modport slave (
    input  stall, redir_valid, redir_target,
    output pc, pc_plus, pend_valid, redir_src, flush
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered program counter with N prioritised redirect sources and a
// one-entry buffer that keeps a redirect alive across a stall.
module pc_next_unit #(
  parameter int PC_W     = 9,
  parameter int DATA_W   = 32,
  parameter int N_SRC    = 3,
  parameter int INC      = 4,
  parameter int RESET_PC = 0
) (
  input logic    clk,
  input logic    reset,
  pc_next_if.slave bus
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PC_W-1:0]  pc_q;
  logic             pend_q;
  logic [IDX_W-1:0] pend_idx_q;
  logic [PC_W-1:0]  pend_tgt_q;

  logic             live_hit;
  logic [IDX_W-1:0] live_idx;
  logic [PC_W-1:0]  live_tgt;
  logic             take_live;
  logic             cand_hit;
  logic [IDX_W-1:0] cand_idx;
  logic [PC_W-1:0]  cand_tgt;
  logic             apply;
  logic [PC_W-1:0]  pc_inc;

  // Scan from the youngest source down so the lowest index ends up winning.
  always_comb begin
    live_hit = 1'b0;
    live_idx = '0;
    live_tgt = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) begin
        live_hit = 1'b1;
        live_idx = IDX_W'(i);
        live_tgt = bus.redir_target[i*DATA_W +: PC_W];
      end
    end
  end

  // On an index tie the live request carries the newer target of that stage.
  always_comb begin
    take_live = live_hit && (!pend_q || (live_idx <= pend_idx_q));
    cand_hit  = take_live || pend_q;
    cand_idx  = take_live ? live_idx : pend_idx_q;
    cand_tgt  = take_live ? live_tgt : pend_tgt_q;
    apply     = cand_hit && !bus.stall && !reset;
  end

  assign pc_inc         = pc_q + PC_W'(INC);
  assign bus.pc         = pc_q;
  assign bus.pc_plus    = pc_inc;
  assign bus.pend_valid = pend_q;
  assign bus.flush      = apply;
  assign bus.redir_src  = apply ? (N_SRC'(1) << cand_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_W'(RESET_PC);
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      pend_tgt_q <= '0;
    end else if (bus.stall) begin
      // Lower-priority arrivals are dropped: their instruction gets squashed.
      if (take_live) begin
        pend_q     <= 1'b1;
        pend_idx_q <= live_idx;
        pend_tgt_q <= live_tgt;
      end
    end else if (cand_hit) begin
      pc_q   <= cand_tgt;
      pend_q <= 1'b0;
    end else begin
      pc_q <= pc_inc;
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: sequential fetch, priority, stall buffering,
// wrap-around and reset behaviour, each with hand-computed expectations.
module tb_pc_next_unit;
  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  pc_next_if #(.PC_W(9), .DATA_W(32), .N_SRC(3)) bus ();

  pc_next_unit #(
    .PC_W(9), .DATA_W(32), .N_SRC(3), .INC(4), .RESET_PC(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redir_valid = 3'b001;
    bus.redir_target = {32'h0, 32'h0, 32'h0000_0100};
    step();
    step();
    compared++; if (bus.pc !== 9'h000) begin mismatched++; $display("[TB] FAIL reset_pc got %h exp %h", bus.pc, 9'h000); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pend got %b exp 0", bus.pend_valid); end
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flush got %b exp 0", bus.flush); end
    compared++; if (bus.redir_src !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_src got %b exp 000", bus.redir_src); end
    reset = 1'b0;
    bus.redir_valid = 3'b000;
  endtask

  task automatic test_sequential();
    logic [8:0] exp_pc;
    #1;
    compared++; if (bus.pc_plus !== 9'h004) begin mismatched++; $display("[TB] FAIL seq_plus0 got %h exp %h", bus.pc_plus, 9'h004); end
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_pc = 9'(4 * k);
      compared++; if (bus.pc !== exp_pc) begin mismatched++; $display("[TB] FAIL seq_pc%0d got %h exp %h", k, bus.pc, exp_pc); end
      compared++; if ({bus.flush, bus.pend_valid} !== 2'b00) begin mismatched++; $display("[TB] FAIL seq_flags%0d got %b exp 00", k, {bus.flush, bus.pend_valid}); end
    end
  endtask

  task automatic test_priority();
    step();
    compared++; if (bus.pc !== 9'h010) begin mismatched++; $display("[TB] FAIL prio_start got %h exp %h", bus.pc, 9'h010); end
    bus.redir_valid = 3'b110;
    bus.redir_target = {32'h0000_0040, 32'h0000_1234, 32'h0};
    #1;
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("[TB] FAIL prio_flush got %b exp 1", bus.flush); end
    compared++; if (bus.redir_src !== 3'b010) begin mismatched++; $display("[TB] FAIL prio_src got %b exp 010", bus.redir_src); end
    step();
    bus.redir_valid = 3'b000;
    #1;
    compared++; if (bus.pc !== 9'h034) begin mismatched++; $display("[TB] FAIL prio_pc got %h exp %h", bus.pc, 9'h034); end
    compared++; if (bus.pc_plus !== 9'h038) begin mismatched++; $display("[TB] FAIL prio_plus got %h exp %h", bus.pc_plus, 9'h038); end
  endtask

  task automatic test_stall_buffer();
    bus.stall = 1'b1;
    bus.redir_valid = 3'b100;
    bus.redir_target = {32'h0000_0080, 32'h0, 32'h0};
    #1;
    compared++; if ({bus.flush, bus.redir_src} !== 4'b0000) begin mismatched++; $display("[TB] FAIL stall_noflush got %b exp 0000", {bus.flush, bus.redir_src}); end
    step();
    bus.redir_valid = 3'b000;
    for (int k = 0; k < 2; k++) begin
      compared++; if (bus.pend_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_pend%0d got %b exp 1", k, bus.pend_valid); end
      compared++; if (bus.pc !== 9'h034) begin mismatched++; $display("[TB] FAIL stall_hold%0d got %h exp %h", k, bus.pc, 9'h034); end
      step();
    end
    bus.stall = 1'b0;
    #1;
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("[TB] FAIL release_flush got %b exp 1", bus.flush); end
    compared++; if (bus.redir_src !== 3'b100) begin mismatched++; $display("[TB] FAIL release_src got %b exp 100", bus.redir_src); end
    step();
    compared++; if (bus.pc !== 9'h080) begin mismatched++; $display("[TB] FAIL release_pc got %h exp %h", bus.pc, 9'h080); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL release_pend got %b exp 0", bus.pend_valid); end
  endtask

  task automatic test_pending_replace();
    bus.stall = 1'b1;
    bus.redir_valid = 3'b100;
    bus.redir_target = {32'h0000_0080, 32'h0, 32'h0};
    step();
    bus.redir_valid = 3'b001;
    bus.redir_target = {32'h0, 32'h0, 32'hFFFF_F1F0};
    step();
    bus.redir_valid = 3'b100;
    bus.redir_target = {32'h0000_0044, 32'h0, 32'h0};
    step();
    compared++; if (bus.pc !== 9'h080) begin mismatched++; $display("[TB] FAIL repl_hold got %h exp %h", bus.pc, 9'h080); end
    bus.stall = 1'b0;
    bus.redir_valid = 3'b010;
    bus.redir_target = {32'h0, 32'h0000_00C0, 32'h0};
    #1;
    compared++; if (bus.redir_src !== 3'b001) begin mismatched++; $display("[TB] FAIL repl_src got %b exp 001", bus.redir_src); end
    step();
    bus.redir_valid = 3'b000;
    #1;
    compared++; if (bus.pc !== 9'h1F0) begin mismatched++; $display("[TB] FAIL repl_pc got %h exp %h", bus.pc, 9'h1F0); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL repl_pend got %b exp 0", bus.pend_valid); end
  endtask

  task automatic test_wrap();
    bus.redir_valid = 3'b001;
    bus.redir_target = {32'h0, 32'h0, 32'h0000_01FC};
    step();
    bus.redir_valid = 3'b000;
    #1;
    compared++; if (bus.pc !== 9'h1FC) begin mismatched++; $display("[TB] FAIL wrap_start got %h exp %h", bus.pc, 9'h1FC); end
    compared++; if (bus.pc_plus !== 9'h000) begin mismatched++; $display("[TB] FAIL wrap_plus0 got %h exp %h", bus.pc_plus, 9'h000); end
    step();
    compared++; if (bus.pc !== 9'h000) begin mismatched++; $display("[TB] FAIL wrap_pc got %h exp %h", bus.pc, 9'h000); end
    compared++; if (bus.pc_plus !== 9'h004) begin mismatched++; $display("[TB] FAIL wrap_plus1 got %h exp %h", bus.pc_plus, 9'h004); end
    step();
    compared++; if (bus.pc !== 9'h004) begin mismatched++; $display("[TB] FAIL wrap_pc1 got %h exp %h", bus.pc, 9'h004); end
  endtask

  task automatic test_back_to_back();
    bus.redir_valid = 3'b001;
    bus.redir_target = {32'h0, 32'h0, 32'h0000_00A0};
    step();
    compared++; if (bus.pc !== 9'h0A0) begin mismatched++; $display("[TB] FAIL b2b_pc0 got %h exp %h", bus.pc, 9'h0A0); end
    bus.redir_valid = 3'b100;
    bus.redir_target = {32'h0000_01C3, 32'h0, 32'h0};
    step();
    compared++; if (bus.pc !== 9'h1C3) begin mismatched++; $display("[TB] FAIL b2b_pc1 got %h exp %h", bus.pc, 9'h1C3); end
    bus.stall = 1'b1;
    bus.redir_valid = 3'b010;
    bus.redir_target = {32'h0, 32'h0000_0020, 32'h0};
    step();
    bus.stall = 1'b0;
    bus.redir_target = {32'h0, 32'h0000_0030, 32'h0};
    #1;
    compared++; if (bus.redir_src !== 3'b010) begin mismatched++; $display("[TB] FAIL tie_src got %b exp 010", bus.redir_src); end
    step();
    bus.redir_valid = 3'b000;
    #1;
    compared++; if (bus.pc !== 9'h030) begin mismatched++; $display("[TB] FAIL tie_pc got %h exp %h", bus.pc, 9'h030); end
  endtask

  task automatic test_reset_mid_stall();
    bus.stall = 1'b1;
    bus.redir_valid = 3'b010;
    bus.redir_target = {32'h0, 32'h0000_0100, 32'h0};
    step();
    compared++; if (bus.pend_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL rms_pend got %b exp 1", bus.pend_valid); end
    bus.redir_valid = 3'b000;
    reset = 1'b1;
    #1;
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("[TB] FAIL rms_flush got %b exp 0", bus.flush); end
    step();
    compared++; if (bus.pc !== 9'h000) begin mismatched++; $display("[TB] FAIL rms_pc got %h exp %h", bus.pc, 9'h000); end
    compared++; if (bus.pend_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rms_pend_clr got %b exp 0", bus.pend_valid); end
    reset = 1'b0;
    bus.stall = 1'b0;
    #1;
    compared++; if ({bus.flush, bus.redir_src} !== 4'b0000) begin mismatched++; $display("[TB] FAIL rms_noflush got %b exp 0000", {bus.flush, bus.redir_src}); end
    step();
    compared++; if (bus.pc !== 9'h004) begin mismatched++; $display("[TB] FAIL rms_next got %h exp %h", bus.pc, 9'h004); end
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redir_valid = '0;
    bus.redir_target = '0;
    test_reset();
    test_sequential();
    test_priority();
    test_stall_buffer();
    test_pending_replace();
    test_wrap();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Registered program-counter stage for the pipelined RISC-V core; generalises the 3-way next-PC select into N prioritised redirect sources plus sequential increment.
- Holds PC under stall and buffers redirects arriving during a stall so none are lost.
- Produces the fetch PC, PC+INC and a one-cycle flush pulse for the IF/ID pipeline registers.

Parameters:
- PC_W, 9, width of PC; redirect targets truncated to their low PC_W bits.
- DATA_W, 32, width of each redirect target input (e.g. the ALU result).
- N_SRC, 3, number of redirect sources; index 0 = highest priority (oldest pipeline stage).
- INC, 4, sequential increment added to PC.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- stall  in  1  hold PC this cycle.
- redir_valid  in  N_SRC  per-source redirect request.
- redir_target  in  N_SRC*DATA_W  flattened targets; source i at [i*DATA_W +: DATA_W].
- pc  out  PC_W  current fetch PC (registered).
- pc_plus  out  PC_W  (pc + INC) mod 2^PC_W, combinational.
- pend_valid  out  1  a redirect is buffered awaiting stall release (registered).
- redir_src  out  N_SRC  one-hot source applied to PC this cycle; 0 if none.
- flush  out  1  high in the cycle a redirect is applied (PC loads a target).

Behaviour:
- Reset (dominates all inputs): pc=RESET_PC, pend_valid=0, pending index/target=0; redir_src=0 and flush=0 while reset high.
- Live winner: lowest index i with redir_valid[i]=1; target = redir_target[i][PC_W-1:0] (upper bits ignored).
- Candidate for this cycle: pending entry vs live winner; lower index wins; equal index -> live wins (newer target of same stage).
- stall=0, candidate exists: pc <= candidate target; redir_src = one-hot(candidate index); flush=1; pend_valid <= 0.
- stall=0, no candidate: pc <= pc_plus; flush=0; redir_src=0.
- stall=1: pc holds; flush=0; redir_src=0. If a live winner exists and (pend_valid=0 or live index <= pending index): pending <= live index/target, pend_valid <= 1. Otherwise pending unchanged (lower-priority redirect dropped — younger instruction is squashed anyway).
- Latency: redirect presented with stall=0 appears on pc next cycle; flush asserted same cycle as request (combinational from inputs + pending state).
- Wrap-around: pc_plus and pc arithmetic modulo 2^PC_W; pc=2^PC_W-INC -> next pc=0.
- Multiple simultaneous valids: only the winner is observable; others ignored that cycle (not buffered).
- Reset mid-stall with pending entry: pending discarded, pc=RESET_PC next cycle.
- No alignment checking; misaligned targets loaded as given.

Test Plan:
- Reset then 3 free cycles, no redirects -> pc sequence 0,4,8,12; flush=0, pend_valid=0.
- pc=0x010, redir_valid=3'b110, targets src1=0x0000_1234, src2=0x40 -> flush=1, redir_src=3'b010; next pc=0x034 (low 9 bits of 0x1234).
- stall=1 with redir_valid[2]=1 target 0x80, then stall=1 two more cycles idle, then stall=0 -> pend_valid=1 during stall, pc held; on release flush=1, redir_src=3'b100, next pc=0x080, pend_valid=0.
- Under stall: src2 (0x80) buffered, then src0 (0x1F0) arrives still stalled, then src1 (0x0C0) live at release -> pending replaced by src0; at release src0 beats live src1; pc=0x1F0.
- pc=0x1FC, no stall/redirect -> next pc=0x000, pc_plus wraps to 0x000 then 0x004.
- pend_valid=1 (src1, 0x100) then reset asserted one cycle while stall=1 -> pc=RESET_PC, pend_valid=0; after reset release with stall=0, pc goes RESET_PC+4, no flush.
